// File: rtl/acc_job_arbiter_pkg.sv
// Shared types and default constants for the accelerator job arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package acc_arb_pkg;

  // FSM encoding; values are fixed so debug tools can decode the state register.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int N_REQ_DEF          = 4;
  localparam int CNT_W_DEF          = 32;
  localparam int TIMEOUT_CYCLES_DEF = 60000000;

endpackage

// File: rtl/acc_job_arbiter_if.sv
// Requester-side and accelerator-side signals of the job arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held until the matching done pulse.
interface acc_job_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 32
);
  logic [N_REQ-1:0] i_req;
  logic [N_REQ-1:0] o_grant;
  logic [N_REQ-1:0] o_done;
  logic             o_error;
  logic             o_busy;
  logic [CNT_W-1:0] o_cycles;
  logic             o_acc_start;
  logic             i_acc_finish;

  // Arbiter side.
  modport master (
    input  i_req, i_acc_finish,
    output o_grant, o_done, o_error, o_busy, o_cycles, o_acc_start
  );

  // Requester / accelerator side.
  modport slave (
    output i_req, i_acc_finish,
    input  o_grant, o_done, o_error, o_busy, o_cycles, o_acc_start
  );
endinterface

// File: rtl/acc_rr_picker.sv
// Round-robin pick: first set request at or above the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; valid is low when no request is set.
module acc_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             vld
);

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int             j;
      logic [IW-1:0]  jj;
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = j[IW-1:0];
      if (!vld && req[jj]) begin
        vld       = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/acc_job_arbiter.sv
// Shares one accelerator among N_REQ requesters round-robin; optional abort via ACC_ARB_TIMEOUT_EN.
// Latency: request in IDLE at t -> grant/start at t+1; finish at f -> done at f+1; next start >= f+3.
// Backpressure: requests wait as levels while the accelerator is owned; no queueing.
module acc_job_arbiter
  import acc_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
`ifdef ACC_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input logic               clk,
  input logic               reset,
  acc_job_arbiter_if.master bus
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t       state;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;
  logic             start_q;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    owner_q;

  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;

  acc_rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req   (bus.i_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  // Busy counter sticks at all-ones rather than wrapping.
  assign cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef ACC_ARB_TIMEOUT_EN
  logic error_q;
  assign bus.o_error = error_q;
`else
  assign bus.o_error = 1'b0;
`endif

  // Job FSM: all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      cycles_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
`ifdef ACC_ARB_TIMEOUT_EN
      error_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_grant;
            owner_q <= pick_idx;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
            state   <= START;
          end
        end
        START: begin
          // Start is level-sensitive at the accelerator: drop it after one cycle.
          start_q <= 1'b0;
          cnt_q   <= cnt_nxt;
          state   <= BUSY;
        end
        BUSY: begin
          if (bus.i_acc_finish) begin
            cycles_q <= cnt_q;
            done_q   <= grant_q;
            state    <= DONE;
`ifdef ACC_ARB_TIMEOUT_EN
          end else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES)) begin
            cycles_q <= CNT_W'(TIMEOUT_CYCLES);
            done_q   <= grant_q;
            error_q  <= 1'b1;
            state    <= DONE;
`endif
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
        DONE: begin
          done_q  <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          state   <= IDLE;
`ifdef ACC_ARB_TIMEOUT_EN
          error_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_done      = done_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_cycles    = cycles_q;
  assign bus.o_acc_start = start_q;

endmodule

// File: tb/tb_acc_job_arbiter.sv
// Directed bench for acc_job_arbiter with a fixed-latency accelerator model.
// Latency: model raises finish acc_lat cycles after the start cycle.
// Backpressure: requests held as levels by the scenario tasks.
module tb_acc_job_arbiter;
  import acc_arb_pkg::*;

  localparam int NR = 4;
  localparam int CW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic fin_model = 1'b0;
  logic fin_force = 1'b0;
  int   acc_lat   = 10;
  bit   acc_en    = 1'b1;
  int   cd        = 0;

  acc_job_arbiter_if #(.N_REQ(NR), .CNT_W(CW)) bus ();
  assign bus.i_acc_finish = fin_model | fin_force;

`ifdef ACC_ARB_TIMEOUT_EN
  acc_job_arbiter #(.N_REQ(NR), .CNT_W(CW), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`else
  acc_job_arbiter #(.N_REQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Accelerator model: finish is high during cycle start+acc_lat.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      cd        = 0;
      fin_model = 1'b0;
    end else begin
      fin_model = 1'b0;
      if (acc_en && bus.o_acc_start) cd = acc_lat;
      else if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) fin_model = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Steps until o_done is seen; returns cycles taken (k) and whether it was seen.
  task automatic wait_done(output int k, output bit seen);
    k    = 0;
    seen = 1'b0;
    while (k < 200 && !seen) begin
      step();
      k++;
      if (bus.o_done !== '0) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    bus.i_req  = '0;
    fin_force  = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.i_req = '0;
    repeat (2) step();
    n_chk++; if (bus.o_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant got %b want 0000", bus.o_grant); end
    n_chk++; if (bus.o_done !== 4'b0) begin n_fail++; $display("FAIL reset_done got %b want 0000", bus.o_done); end
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    n_chk++; if (bus.o_acc_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", bus.o_acc_start); end
    n_chk++; if (bus.o_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_cycles got %0d want 0", bus.o_cycles); end
    n_chk++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", bus.o_error); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_job();
    int k; bit seen;
    step(); step();
    bus.i_req = 4'b0001;
    step();
    n_chk++; if (bus.o_grant !== 4'b0001 || bus.o_acc_start !== 1'b1 || bus.o_busy !== 1'b1) begin
      n_fail++; $display("FAIL single_start grant=%b start=%b busy=%b want 0001/1/1", bus.o_grant, bus.o_acc_start, bus.o_busy); end
    bus.i_req = 4'b0000;
    wait_done(k, seen);
    n_chk++; if (!seen || k != 11) begin n_fail++; $display("FAIL single_latency got %0d seen=%0d want 11", k, seen); end
    n_chk++; if (bus.o_done !== 4'b0001 || bus.o_grant !== 4'b0001) begin
      n_fail++; $display("FAIL single_done done=%b grant=%b want 0001/0001", bus.o_done, bus.o_grant); end
    n_chk++; if (bus.o_cycles !== 32'd11) begin n_fail++; $display("FAIL single_cycles got %0d want 11", bus.o_cycles); end
    n_chk++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL single_error got %b want 0", bus.o_error); end
    step();
    n_chk++; if (bus.o_grant !== 4'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 4'b0) begin
      n_fail++; $display("FAIL single_idle grant=%b busy=%b done=%b want 0000/0/0000", bus.o_grant, bus.o_busy, bus.o_done); end
    n_chk++; if (bus.o_cycles !== 32'd11) begin n_fail++; $display("FAIL single_cycles_hold got %0d want 11", bus.o_cycles); end
  endtask

  task automatic test_ignore_finish();
    int k; bit seen;
    fin_force = 1'b1;
    step();
    fin_force = 1'b0;
    step();
    n_chk++; if (bus.o_busy !== 1'b0 || bus.o_done !== 4'b0) begin
      n_fail++; $display("FAIL fin_idle busy=%b done=%b want 0/0000", bus.o_busy, bus.o_done); end
    bus.i_req = 4'b0010;
    step();
    n_chk++; if (bus.o_grant !== 4'b0010 || bus.o_acc_start !== 1'b1) begin
      n_fail++; $display("FAIL fin_grant grant=%b start=%b want 0010/1", bus.o_grant, bus.o_acc_start); end
    fin_force = 1'b1;
    step();
    fin_force = 1'b0;
    n_chk++; if (bus.o_done !== 4'b0 || bus.o_busy !== 1'b1) begin
      n_fail++; $display("FAIL fin_start done=%b busy=%b want 0000/1", bus.o_done, bus.o_busy); end
    wait_done(k, seen);
    n_chk++; if (!seen || k != 10 || bus.o_done !== 4'b0010) begin
      n_fail++; $display("FAIL fin_real k=%0d done=%b want 10/0010", k, bus.o_done); end
    bus.i_req = 4'b0000;
    step();
  endtask

  task automatic test_all_req();
    int jobs, dbl, cyc, last_done;
    logic prev, seen_done;
    logic [3:0] exp_g;
    int k; bit seen;
    do_reset();
    bus.i_req = 4'b1111;
    jobs = 0; dbl = 0; cyc = 0; last_done = -1; prev = 1'b0; seen_done = 1'b0;
    while (cyc < 400 && jobs < 8) begin
      step();
      cyc++;
      if (bus.o_acc_start && prev) dbl++;
      if (bus.o_done !== 4'b0) begin last_done = cyc; seen_done = 1'b1; end
      if (bus.o_acc_start) begin
        exp_g = 4'b0001 << (jobs % 4);
        n_chk++; if (bus.o_grant !== exp_g) begin
          n_fail++; $display("FAIL rr_grant job %0d got %b want %b", jobs, bus.o_grant, exp_g); end
        if (seen_done && jobs == 1) begin
          n_chk++; if (cyc - last_done != 2) begin
            n_fail++; $display("FAIL rr_gap got %0d want 2", cyc - last_done); end
        end
        jobs++;
      end
      prev = bus.o_acc_start;
    end
    n_chk++; if (jobs != 8) begin n_fail++; $display("FAIL rr_jobs got %0d want 8", jobs); end
    bus.i_req = 4'b0000;
    wait_done(k, seen);
    step();
    n_chk++; if (dbl != 0) begin n_fail++; $display("FAIL rr_start_double got %0d want 0", dbl); end
  endtask

  task automatic test_drop_busy();
    int k; bit seen;
    bus.i_req = 4'b1100;
    step();
    n_chk++; if (bus.o_grant !== 4'b0100) begin n_fail++; $display("FAIL drop_grant got %b want 0100", bus.o_grant); end
    repeat (3) step();
    bus.i_req = 4'b1000;
    wait_done(k, seen);
    n_chk++; if (!seen || bus.o_done !== 4'b0100) begin
      n_fail++; $display("FAIL drop_done got %b seen=%0d want 0100", bus.o_done, seen); end
    step(); step();
    n_chk++; if (bus.o_grant !== 4'b1000 || bus.o_acc_start !== 1'b1) begin
      n_fail++; $display("FAIL drop_next grant=%b start=%b want 1000/1", bus.o_grant, bus.o_acc_start); end
    wait_done(k, seen);
    bus.i_req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    int k; bit seen;
    bus.i_req = 4'b0100;
    step();
    wait_done(k, seen);
    step();
    step(); step();
    n_chk++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre got %b want 1", bus.o_busy); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (bus.o_grant !== 4'b0 || bus.o_busy !== 1'b0 || bus.o_acc_start !== 1'b0) begin
      n_fail++; $display("FAIL mid_async grant=%b busy=%b start=%b want 0000/0/0", bus.o_grant, bus.o_busy, bus.o_acc_start); end
    bus.i_req = 4'b1010;
    step(); step();
    reset = 1'b1;
    step();
    n_chk++; if (bus.o_grant !== 4'b0010) begin n_fail++; $display("FAIL mid_ptr_restart got %b want 0010", bus.o_grant); end
    wait_done(k, seen);
    bus.i_req = 4'b0000;
    step();
  endtask

`ifdef ACC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k; bit seen;
    acc_en    = 1'b0;
    bus.i_req = 4'b0001;
    step();
    wait_done(k, seen);
    n_chk++; if (!seen || k != 20) begin n_fail++; $display("FAIL to_latency got %0d want 20", k); end
    n_chk++; if (bus.o_error !== 1'b1 || bus.o_done !== 4'b0001) begin
      n_fail++; $display("FAIL to_error err=%b done=%b want 1/0001", bus.o_error, bus.o_done); end
    n_chk++; if (bus.o_cycles !== 32'd20) begin n_fail++; $display("FAIL to_cycles got %0d want 20", bus.o_cycles); end
    bus.i_req = 4'b0000;
    step();
    n_chk++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL to_error_clear got %b want 0", bus.o_error); end
    acc_en    = 1'b1;
    acc_lat   = 19;
    bus.i_req = 4'b0001;
    step();
    wait_done(k, seen);
    n_chk++; if (!seen || k != 20 || bus.o_error !== 1'b0) begin
      n_fail++; $display("FAIL to_finish_wins k=%0d err=%b want 20/0", k, bus.o_error); end
    n_chk++; if (bus.o_cycles !== 32'd20) begin n_fail++; $display("FAIL to_finish_cycles got %0d want 20", bus.o_cycles); end
    bus.i_req = 4'b0000;
    acc_lat   = 10;
    step();
  endtask
`endif

  initial begin
    bus.i_req = '0;
    test_reset();
    test_single_job();
    test_ignore_finish();
    test_all_req();
    test_drop_busy();
    test_reset_mid();
`ifdef ACC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
